// File: rtl/systolic_feeder.sv
// Operand buffer and skewed stream driver for the 4x4 systolic array: 1-cycle clear, 3N-2 feed steps, drain, done.
// Stream outputs are registered; writes and start are only honoured in IDLE, so the host must wait for busy low.
module systolic_feeder #(
    parameter int DATA_W    = 32,
    parameter int N         = 4,
    parameter int DRAIN_CYC = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic              i_wr_mat,
    input  logic [3:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_start,
    output logic [DATA_W-1:0] o_west0,
    output logic [DATA_W-1:0] o_west4,
    output logic [DATA_W-1:0] o_west8,
    output logic [DATA_W-1:0] o_west12,
    output logic [DATA_W-1:0] o_north0,
    output logic [DATA_W-1:0] o_north1,
    output logic [DATA_W-1:0] o_north2,
    output logic [DATA_W-1:0] o_north3,
    output logic              o_arr_clr,
    output logic              o_busy,
    output logic              o_done
);

    localparam int LAST_STEP = 3 * N - 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_step;
    logic [7:0]        r_drain;
    logic              r_arr_clr;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_mat_a [16];
    logic [DATA_W-1:0] r_mat_b [16];
    logic [DATA_W-1:0] r_west  [4];
    logic [DATA_W-1:0] r_north [4];

    logic              w_feed_nxt;
    logic [3:0]        w_step_nxt;
    logic [DATA_W-1:0] w_west  [4];
    logic [DATA_W-1:0] w_north [4];

    // Streams are computed from the step that will be live after the edge,
    // so the registered outputs line up with the FEED step they belong to.
    always_comb begin
        w_feed_nxt = 1'b0;
        w_step_nxt = 4'd0;
        if (r_state == S_CLEAR) begin
            w_feed_nxt = 1'b1;
        end else if (r_state == S_FEED && r_step != 4'(LAST_STEP)) begin
            w_feed_nxt = 1'b1;
            w_step_nxt = r_step + 4'd1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_skew
        logic [3:0] w_k;
        logic       w_in_win;
        assign w_k      = w_step_nxt - 4'(g);
        assign w_in_win = w_feed_nxt && (w_step_nxt >= 4'(g)) && (w_k < 4'(N));
        assign w_west[g]  = w_in_win ? r_mat_a[{2'(g), w_k[1:0]}] : '0;
        assign w_north[g] = w_in_win ? r_mat_b[{w_k[1:0], 2'(g)}] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_mat_a[i] <= '0;
                r_mat_b[i] <= '0;
            end
        end else if (r_state == S_IDLE && i_wr_en) begin
            if (i_wr_mat) r_mat_b[i_wr_addr] <= i_wr_data;
            else          r_mat_a[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_step    <= 4'd0;
            r_drain   <= 8'd0;
            r_arr_clr <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_west[i]  <= '0;
                r_north[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_west[i]  <= w_west[i];
                r_north[i] <= w_north[i];
            end
            r_arr_clr <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state   <= S_CLEAR;
                        r_arr_clr <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_FEED;
                    r_step  <= 4'd0;
                end
                S_FEED: begin
                    if (r_step == 4'(LAST_STEP)) begin
                        r_state <= S_DRAIN;
                        r_drain <= 8'(DRAIN_CYC - 1);
                    end else begin
                        r_step <= w_step_nxt;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 8'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_west0   = r_west[0];
    assign o_west4   = r_west[1];
    assign o_west8   = r_west[2];
    assign o_west12  = r_west[3];
    assign o_north0  = r_north[0];
    assign o_north1  = r_north[1];
    assign o_north2  = r_north[2];
    assign o_north3  = r_north[3];
    assign o_arr_clr = r_arr_clr;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
